// File: rtl/adc_sample_capture.sv
`timescale 1ns/1ps
// Dual-channel serial ADC front-end: fixed-rate CONVST/CS/SCLK sequencing, 16-bit capture, sign-extend, offset removal.
// Define ADC_OFFSET_CAL_EN to average the first 16 conversions into a per-channel power-up offset.
module adc_sample_capture #(
  parameter logic [15:0] SAMPLE_PERIOD = 16'd100,
  parameter logic [7:0]  CONVST_WIDTH  = 8'd4,
  parameter logic [7:0]  CONV_TIME     = 8'd30,
  parameter logic [7:0]  SCLK_HALF     = 8'd1,
  parameter logic [4:0]  DATA_BITS     = 5'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               adc_convst,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  input  logic               adc_sdo_i,
  input  logic               adc_sdo_v,
  output logic signed [16:0] sample_current,
  output logic signed [16:0] sample_voltage,
  output logic               sample_valid,
  output logic               sample_overrun,
  output logic               cal_done
);

  localparam logic [15:0] L_PERIOD_LAST = SAMPLE_PERIOD - 16'd1;
  localparam logic [15:0] L_CONVST_LAST = {8'd0, CONVST_WIDTH} - 16'd1;
  localparam logic [15:0] L_WAIT_LAST   = {8'd0, CONV_TIME} - 16'd1;
  localparam logic [15:0] L_HALF_LAST   = {8'd0, SCLK_HALF} - 16'd1;
  localparam logic [4:0]  L_BIT_LAST    = DATA_BITS - 5'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVST,
    S_CONV_WAIT,
    S_READ
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_period;
  logic [15:0]        r_cnt, w_cnt_nxt;
  logic [4:0]         r_bit, w_bit_nxt;
  logic               r_sclk, w_sclk_nxt;
  logic               r_convst, r_cs_n;
  logic               w_tick, w_capture, w_conv_done;
  logic [15:0]        r_shift_i, r_shift_v;
  logic signed [16:0] w_raw_i, w_raw_v, w_off_i, w_off_v;
  logic               w_cal_busy;
  logic signed [16:0] r_sample_i, r_sample_v;
  logic               r_valid, r_overrun;

  // Held at zero while disabled so the first enabled cycle is always a tick.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !enable)                r_period <= '0;
    else if (r_period == L_PERIOD_LAST) r_period <= '0;
    else                               r_period <= r_period + 16'd1;
  end

  assign w_tick = enable && (r_period == 16'd0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_sclk_nxt  = 1'b0;
    w_capture   = 1'b0;
    w_conv_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_CONVST;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_CONVST: begin
        if (r_cnt == L_CONVST_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (CONV_TIME == 8'd0) ? S_READ : S_CONV_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_CONV_WAIT: begin
        if (r_cnt == L_WAIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_READ: begin
        w_sclk_nxt = r_sclk;
        if (r_cnt == L_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_sclk) begin
            // Data is taken on the same edge that raises SCLK.
            w_sclk_nxt = 1'b1;
            w_capture  = 1'b1;
          end else if (r_bit == L_BIT_LAST) begin
            w_sclk_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
            w_conv_done = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            w_bit_nxt  = r_bit + 5'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ADC control lines are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_convst <= 1'b0;
      r_cs_n   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_sclk   <= w_sclk_nxt;
      r_convst <= (w_state_nxt == S_CONVST);
      r_cs_n   <= (w_state_nxt != S_READ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_i <= '0;
      r_shift_v <= '0;
    end else if (w_capture) begin
      r_shift_i <= {r_shift_i[14:0], adc_sdo_i};
      r_shift_v <= {r_shift_v[14:0], adc_sdo_v};
    end
  end

  assign w_raw_i = {r_shift_i[15], r_shift_i};
  assign w_raw_v = {r_shift_v[15], r_shift_v};

`ifdef ADC_OFFSET_CAL_EN
  logic [3:0]         r_cal_cnt;
  logic               r_cal_done;
  logic signed [19:0] r_acc_i, r_acc_v, w_acc_i_nxt, w_acc_v_nxt;
  logic signed [16:0] r_off_i, r_off_v;

  assign w_acc_i_nxt = r_acc_i + {{3{w_raw_i[16]}}, w_raw_i};
  assign w_acc_v_nxt = r_acc_v + {{3{w_raw_v[16]}}, w_raw_v};

  // Offset is the mean of 16 samples: arithmetic shift keeps bits [19:4] of the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cal_cnt  <= '0;
      r_cal_done <= 1'b0;
      r_acc_i    <= '0;
      r_acc_v    <= '0;
      r_off_i    <= '0;
      r_off_v    <= '0;
    end else if (w_conv_done && !r_cal_done) begin
      r_acc_i   <= w_acc_i_nxt;
      r_acc_v   <= w_acc_v_nxt;
      r_cal_cnt <= r_cal_cnt + 4'd1;
      if (r_cal_cnt == 4'd15) begin
        r_cal_done <= 1'b1;
        r_off_i    <= {w_acc_i_nxt[19], w_acc_i_nxt[19:4]};
        r_off_v    <= {w_acc_v_nxt[19], w_acc_v_nxt[19:4]};
      end
    end
  end

  assign w_off_i    = r_off_i;
  assign w_off_v    = r_off_v;
  assign w_cal_busy = !r_cal_done;
  assign cal_done   = r_cal_done;
`else
  assign w_off_i    = '0;
  assign w_off_v    = '0;
  assign w_cal_busy = 1'b0;
  assign cal_done   = 1'b1;
`endif

  // Overrun strobe is registered, so it appears the cycle after the dropped tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_i <= '0;
      r_sample_v <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid   <= w_conv_done && !w_cal_busy;
      r_overrun <= w_tick && (r_state != S_IDLE);
      if (w_conv_done && !w_cal_busy) begin
        r_sample_i <= w_raw_i - w_off_i;
        r_sample_v <= w_raw_v - w_off_v;
      end
    end
  end

  assign adc_convst     = r_convst;
  assign adc_cs_n       = r_cs_n;
  assign adc_sclk       = r_sclk;
  assign sample_current = r_sample_i;
  assign sample_voltage = r_sample_v;
  assign sample_valid   = r_valid;
  assign sample_overrun = r_overrun;

endmodule

// File: tb/tb_adc_sample_capture.sv
`timescale 1ns/1ps
// Self-checking bench for adc_sample_capture: serial ADC models, vector table, random words, timing corner cases.
module tb_adc_sample_capture;

  localparam int CW  = 4;
  localparam int CT  = 30;
  localparam int SH  = 1;
  localparam int DB  = 16;
  localparam int LAT = 1 + CW + CT + 2 * SH * DB;
  localparam int OVR_PERIOD = 40;
  localparam int OVR_SPAN   = 400;

  typedef struct {
    logic [15:0] raw_i;
    logic [15:0] raw_v;
    int          exp_i;
    int          exp_v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic en2 = 1'b0;

  logic adc_convst, adc_cs_n, adc_sclk, adc_sdo_i, adc_sdo_v;
  logic signed [16:0] sample_current, sample_voltage;
  logic sample_valid, sample_overrun, cal_done;

  logic convst_2, cs_n_2, sclk_2, sdo_i_2, sdo_v_2;
  logic signed [16:0] cur_2, volt_2;
  logic valid_2, ovr_2, cal_2;

  logic [15:0] adc_i = '0, adc_v = '0, sh_i = '0, sh_v = '0;
  logic [15:0] adc2_i = 16'h0ABC, adc2_v = 16'hF123, sh2_i = '0, sh2_v = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_capture dut (
    .clk(clk), .rst(rst), .enable(enable),
    .adc_convst(adc_convst), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_sdo_i(adc_sdo_i), .adc_sdo_v(adc_sdo_v),
    .sample_current(sample_current), .sample_voltage(sample_voltage),
    .sample_valid(sample_valid), .sample_overrun(sample_overrun), .cal_done(cal_done)
  );

  adc_sample_capture #(.SAMPLE_PERIOD(16'd40)) dut_ovr (
    .clk(clk), .rst(rst), .enable(en2),
    .adc_convst(convst_2), .adc_cs_n(cs_n_2), .adc_sclk(sclk_2),
    .adc_sdo_i(sdo_i_2), .adc_sdo_v(sdo_v_2),
    .sample_current(cur_2), .sample_voltage(volt_2),
    .sample_valid(valid_2), .sample_overrun(ovr_2), .cal_done(cal_2)
  );

  // ADC models: word latched when CS falls, next bit presented after each SCLK rise.
  always @(negedge adc_cs_n or posedge adc_sclk) begin
    if (adc_sclk) begin
      sh_i = {sh_i[14:0], 1'b0};
      sh_v = {sh_v[14:0], 1'b0};
    end else begin
      sh_i = adc_i;
      sh_v = adc_v;
    end
  end
  assign adc_sdo_i = sh_i[15];
  assign adc_sdo_v = sh_v[15];

  always @(negedge cs_n_2 or posedge sclk_2) begin
    if (sclk_2) begin
      sh2_i = {sh2_i[14:0], 1'b0};
      sh2_v = {sh2_v[14:0], 1'b0};
    end else begin
      sh2_i = adc2_i;
      sh2_v = adc2_v;
    end
  end
  assign sdo_i_2 = sh2_i[15];
  assign sdo_v_2 = sh2_v[15];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int waited, output bit seen);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < budget) begin
      step();
      waited++;
      seen = sample_valid;
    end
  endtask

  // Two's complement interpretation of a 16-bit ADC word, minus a calibration offset.
  function automatic int model_sample(input logic [15:0] raw, input int off);
    int v;
    v = int'(raw);
    if (v >= 32768) v = v - 65536;
    return v - off;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   waited, off_i, off_v;
    bit   seen;
    int   cv_first, cv_last, cv_n, cs_first, cs_last, cs_n_low, sclk_rises, n_valid;
    int   valid_at[2];
    logic prev_sclk;
    int   cnt_cv, cnt_val, busy_end;
    bit   exp_v2[OVR_SPAN+1];
    bit   exp_o2[OVR_SPAN+1];
    logic [15:0] r_i, r_v;

    vecs[0] = '{16'h1234, 16'hFFF0, 4660, -16};
    vecs[1] = '{16'h8000, 16'h7FFF, -32768, 32767};
    vecs[2] = '{16'h0000, 16'hFFFF, 0, -1};
    vecs[3] = '{16'h7FFF, 16'h0001, 32767, 1};
    off_i = 0;
    off_v = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_convst", adc_convst, 0);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_cur", sample_current, 0);
    check("rst_volt", sample_voltage, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", sample_overrun, 0);
`ifdef ADC_OFFSET_CAL_EN
    check("rst_cal_done", cal_done, 0);
`else
    check("rst_cal_done", cal_done, 1);
`endif
    rst = 1'b0;
    cnt_cv = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (adc_convst) cnt_cv++;
    end
    check("disabled_no_convst", cnt_cv, 0);

`ifdef ADC_OFFSET_CAL_EN
    begin
      int rises, early, sum_i, sum_v, k;
      logic prev_cs;
      adc_i = 16'd100;
      adc_v = 16'hFFEC;
      enable = 1'b1;
      rises = 0; early = 0; sum_i = 0; sum_v = 0; k = 0; n_valid = 0;
      prev_cs = 1'b1;
      while (rises < 16 && k < 2000) begin
        step();
        k++;
        if (sample_valid) n_valid++;
        if (adc_cs_n && !prev_cs) begin
          rises++;
          sum_i += model_sample(adc_i, 0);
          sum_v += model_sample(adc_v, 0);
          if (rises < 16 && cal_done) early++;
        end else if (cal_done) begin
          early++;
        end
        prev_cs = adc_cs_n;
      end
      check("cal_conversions", rises, 16);
      check("cal_no_valid", n_valid, 0);
      check("cal_done_not_early", early, 0);
      check("cal_done_after_16", cal_done, 1);
      off_i = sum_i >>> 4;
      off_v = sum_v >>> 4;
      adc_i = 16'd150;
      adc_v = 16'hFFF6;
      wait_valid(150, waited, seen);
      check("cal_first_valid", seen, 1);
      check("cal_cur", sample_current, 50);
      check("cal_volt", sample_voltage, model_sample(adc_v, off_v));
      last_valid_cyc = cyc;
    end
`else
    // Enable rise: CONVST/CS/SCLK/valid timing against tick cycle 0
    adc_i = vecs[0].raw_i;
    adc_v = vecs[0].raw_v;
    enable = 1'b1;
    cv_first = -1; cv_last = -1; cv_n = 0;
    cs_first = -1; cs_last = -1; cs_n_low = 0;
    sclk_rises = 0; n_valid = 0; prev_sclk = 1'b0;
    valid_at[0] = -1; valid_at[1] = -1;
    for (int k = 1; k <= 170; k++) begin
      step();
      if (k < 100) begin
        if (adc_convst) begin
          if (cv_first < 0) cv_first = k;
          cv_last = k;
          cv_n++;
        end
        if (!adc_cs_n) begin
          if (cs_first < 0) cs_first = k;
          cs_last = k;
          cs_n_low++;
        end
        if (adc_sclk && !prev_sclk) sclk_rises++;
      end
      prev_sclk = adc_sclk;
      if (sample_valid) begin
        if (n_valid < 2) valid_at[n_valid] = k;
        n_valid++;
        check("t_cur", sample_current, vecs[0].exp_i);
        check("t_volt", sample_voltage, vecs[0].exp_v);
        last_valid_cyc = cyc;
      end
    end
    check("t_convst_first", cv_first, 1);
    check("t_convst_last", cv_last, CW);
    check("t_convst_len", cv_n, CW);
    check("t_cs_first", cs_first, 1 + CW + CT);
    check("t_cs_last", cs_last, LAT - 1);
    check("t_cs_len", cs_n_low, 2 * SH * DB);
    check("t_sclk_pulses", sclk_rises, DB);
    check("t_valid_count", n_valid, 2);
    check("t_valid_first", valid_at[0], LAT);
    check("t_valid_second", valid_at[1], LAT + 100);
`endif

    // Table vectors, valid spacing in steady state
    for (int i = 0; i < 4; i++) begin
      adc_i = vecs[i].raw_i;
      adc_v = vecs[i].raw_v;
      wait_valid(150, waited, seen);
      check($sformatf("vec%0d_seen", i), seen, 1);
      check($sformatf("vec%0d_cur", i), sample_current, vecs[i].exp_i - off_i);
      check($sformatf("vec%0d_volt", i), sample_voltage, vecs[i].exp_v - off_v);
      check($sformatf("vec%0d_spacing", i), cyc - last_valid_cyc, 100);
      last_valid_cyc = cyc;
    end

    // Random words against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      r_i = 16'($urandom);
      r_v = 16'($urandom);
      adc_i = r_i;
      adc_v = r_v;
      wait_valid(150, waited, seen);
      check($sformatf("rnd%0d_seen", i), seen, 1);
      check($sformatf("rnd%0d_cur", i), sample_current, model_sample(r_i, off_i));
      check($sformatf("rnd%0d_volt", i), sample_voltage, model_sample(r_v, off_v));
      check($sformatf("rnd%0d_spacing", i), cyc - last_valid_cyc, 100);
      last_valid_cyc = cyc;
    end

`ifndef ADC_OFFSET_CAL_EN
    // Enable dropped mid-conversion
    adc_i = 16'h0F0F;
    adc_v = 16'hF0F0;
    waited = 0;
    while (!adc_convst && waited < 120) begin
      step();
      waited++;
    end
    check("drop_convst_found", adc_convst, 1);
    repeat (39) step();
    enable = 1'b0;
    wait_valid(60, waited, seen);
    check("drop_valid_seen", seen, 1);
    check("drop_valid_latency", waited, LAT - 40);
    check("drop_cur", sample_current, model_sample(16'h0F0F, 0));
    check("drop_volt", sample_voltage, model_sample(16'hF0F0, 0));
    cnt_cv = 0;
    cnt_val = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (adc_convst) cnt_cv++;
      if (sample_valid) cnt_val++;
    end
    check("drop_no_convst", cnt_cv, 0);
    check("drop_no_valid", cnt_val, 0);
    enable = 1'b1;
    step();
    check("reenable_convst", adc_convst, 1);

    // Reset during READ
    repeat (49) step();
    check("mid_read_cs_low", adc_cs_n, 0);
    rst = 1'b1;
    step();
    check("mid_rst_cs_n", adc_cs_n, 1);
    check("mid_rst_sclk", adc_sclk, 0);
    check("mid_rst_convst", adc_convst, 0);
    check("mid_rst_cur", sample_current, 0);
    check("mid_rst_volt", sample_voltage, 0);
    check("mid_rst_valid", sample_valid, 0);
    rst = 1'b0;
    adc_i = 16'h4321;
    adc_v = 16'hC000;
    wait_valid(150, waited, seen);
    check("resume_seen", seen, 1);
    check("resume_latency", waited, LAT);
    check("resume_cur", sample_current, 17185);
    check("resume_volt", sample_voltage, -16384);

    // Short period: every tick while busy is dropped with an overrun strobe
    for (int k = 0; k <= OVR_SPAN; k++) begin
      exp_v2[k] = 1'b0;
      exp_o2[k] = 1'b0;
    end
    busy_end = 0;
    for (int t = 0; t <= OVR_SPAN; t += OVR_PERIOD) begin
      if (t >= busy_end) begin
        if (t + LAT <= OVR_SPAN) exp_v2[t + LAT] = 1'b1;
        busy_end = t + LAT;
      end else if (t + 1 <= OVR_SPAN) begin
        exp_o2[t + 1] = 1'b1;
      end
    end
    en2 = 1'b1;
    cnt_val = 0;
    for (int k = 1; k <= OVR_SPAN; k++) begin
      step();
      if (valid_2 || exp_v2[k]) begin
        check($sformatf("ovr_valid_c%0d", k), valid_2, exp_v2[k]);
        check($sformatf("ovr_cur_c%0d", k), cur_2, model_sample(adc2_i, 0));
        check($sformatf("ovr_volt_c%0d", k), volt_2, model_sample(adc2_v, 0));
        if (valid_2) cnt_val++;
      end
      if (ovr_2 || exp_o2[k]) check($sformatf("ovr_strobe_c%0d", k), ovr_2, exp_o2[k]);
    end
    check("ovr_valid_count", cnt_val, 5);
    en2 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
